// File: rtl/mms_stream_ctrl.sv
// mms_stream_ctrl: frame-level min/max controller over a serial sample stream.
// Optional macro MMS_INDEX_EN adds result_idx (position of the winning sample).
module mms_stream_ctrl #(
   parameter int DW        = 8,
   parameter int FRAME_LEN = 8,
   parameter int CW        = $clog2(FRAME_LEN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          select,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] result,
   output logic          busy
`ifdef MMS_INDEX_EN
   ,
   output logic [CW-1:0] result_idx
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_count;
   logic [DW-1:0] r_acc;
   logic [DW-1:0] r_result;
   logic          r_sel;

   logic          w_accept;
   logic          w_first;
   logic          w_last;
   logic          w_take;
   logic          w_pick;
   logic [DW-1:0] w_acc_nxt;

   // Equal samples never replace the running winner, so ties keep
   // the earlier sample for both max and min.
   assign w_accept  = in_valid && (r_state == S_ACCUM);
   assign w_first   = (r_count == '0);
   assign w_last    = (r_count == CW'(FRAME_LEN - 1));
   assign w_take    = (in_data != r_acc) && ((r_acc < in_data) ^ r_sel);
   assign w_pick    = w_first || w_take;
   assign w_acc_nxt = w_pick ? in_data : r_acc;

   assign result    = r_result;

`ifdef MMS_INDEX_EN
   logic [CW-1:0] r_idx;
   logic [CW-1:0] r_res_idx;
   logic [CW-1:0] w_idx_nxt;

   assign w_idx_nxt  = w_first ? '0 : (w_take ? r_count : r_idx);
   assign result_idx = r_res_idx;

   // Winner index tracks the accumulator; published with the result.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx     <= '0;
         r_res_idx <= '0;
      end else if (w_accept) begin
         r_idx <= w_idx_nxt;
         if (w_last) r_res_idx <= w_idx_nxt;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      unique case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = S_ACCUM;
         end
         S_ACCUM: begin
            in_ready = 1'b1;
            if (w_accept && w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: begin
            busy        = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Datapath: latch mode, count samples, fold the running winner.
   // The result register holds the last frame value until the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count  <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_sel    <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_sel   <= select;
            r_count <= '0;
         end
         if (w_accept) begin
            r_acc   <= w_acc_nxt;
            r_count <= r_count + CW'(1);
            if (w_last) r_result <= w_acc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_mms_stream_ctrl.sv
// tb_mms_stream_ctrl: scoreboard bench for mms_stream_ctrl.
// Two instances: FRAME_LEN=4 (u4) and FRAME_LEN=1 (u1).
module tb_mms_stream_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       start4, select4, in_valid4, out_ready4;
   logic [7:0] in_data4;
   logic       in_ready4, out_valid4, busy4;
   logic [7:0] result4;

   logic       start1, select1, in_valid1, out_ready1;
   logic [7:0] in_data1;
   logic       in_ready1, out_valid1, busy1;
   logic [7:0] result1;

`ifdef MMS_INDEX_EN
   logic [2:0] idx4;
   logic [0:0] idx1;
`endif

   mms_stream_ctrl #(.DW(8), .FRAME_LEN(4)) u4 (
      .clk(clk), .reset(reset), .start(start4), .select(select4),
      .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .result(result4), .busy(busy4)
`ifdef MMS_INDEX_EN
      , .result_idx(idx4)
`endif
   );

   mms_stream_ctrl #(.DW(8), .FRAME_LEN(1)) u1 (
      .clk(clk), .reset(reset), .start(start1), .select(select1),
      .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .result(result1), .busy(busy1)
`ifdef MMS_INDEX_EN
      , .result_idx(idx1)
`endif
   );

   typedef struct {
      logic [7:0] d;
      int         idx;
   } exp_t;

   exp_t q4[$];
   exp_t q1[$];
   exp_t e4, e1;

   int n_cmp = 0;
   int n_err = 0;
   int n_acc4 = 0;
   int n_acc1 = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // accept counters observe the input handshake at the clock edge
   always @(posedge clk) begin
      if (in_valid4 && in_ready4) n_acc4++;
      if (in_valid1 && in_ready1) n_acc1++;
   end

   // monitors: pop and compare on every output handshake
   always @(negedge clk) begin
      if (out_valid4 && out_ready4) begin
         if (q4.size() == 0) chk("sb4_unexpected", 1, 0);
         else begin
            e4 = q4.pop_front();
            chk("sb4_result", {24'd0, result4}, {24'd0, e4.d});
`ifdef MMS_INDEX_EN
            chk("sb4_idx", {29'd0, idx4}, e4.idx);
`endif
         end
      end
      if (out_valid1 && out_ready1) begin
         if (q1.size() == 0) chk("sb1_unexpected", 1, 0);
         else begin
            e1 = q1.pop_front();
            chk("sb1_result", {24'd0, result1}, {24'd0, e1.d});
`ifdef MMS_INDEX_EN
            chk("sb1_idx", {31'd0, idx1}, e1.idx);
`endif
         end
      end
   end

   task automatic start4_t(input logic sel);
      start4  = 1'b1;
      select4 = sel;
      tick();
      start4  = 1'b0;
   endtask

   task automatic feed4(input logic [7:0] d, input int gap);
      int k;
      in_valid4 = 1'b0;
      repeat (gap) tick();
      in_valid4 = 1'b1;
      in_data4  = d;
      k = 0;
      while (!in_ready4 && k < 10) begin
         tick();
         k++;
      end
      if (!in_ready4) chk("in_ready_timeout", 0, 1);
      tick();
      in_valid4 = 1'b0;
   endtask

   task automatic hs4(input string name, input logic [7:0] exp,
                      input int stall);
      int k;
      k = 0;
      while (!out_valid4 && k < 20) begin
         tick();
         k++;
      end
      if (!out_valid4) chk({name, "_outvalid_timeout"}, 0, 1);
      repeat (stall) begin
         chk({name, "_stall_valid"}, {31'd0, out_valid4}, 1);
         chk({name, "_stall_result"}, {24'd0, result4}, {24'd0, exp});
         tick();
      end
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
      chk({name, "_idle_busy"}, {31'd0, busy4}, 0);
      chk({name, "_idle_valid"}, {31'd0, out_valid4}, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      start4 = 0; select4 = 0; in_valid4 = 0; in_data4 = 0; out_ready4 = 0;
      start1 = 0; select1 = 0; in_valid1 = 0; in_data1 = 0; out_ready1 = 0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // reset state
      chk("rst_in_ready", {31'd0, in_ready4}, 0);
      chk("rst_out_valid", {31'd0, out_valid4}, 0);
      chk("rst_busy", {31'd0, busy4}, 0);
      chk("rst_result", {24'd0, result4}, 0);

      // 1: max, no stalls, latency
      start4_t(1'b0);
      chk("t1_busy", {31'd0, busy4}, 1);
      q4.push_back('{8'hF0, 1});
      feed4(8'h12, 0);
      feed4(8'hF0, 0);
      feed4(8'h03, 0);
      feed4(8'h7F, 0);
      chk("t1_latency", {31'd0, out_valid4}, 1);
      hs4("t1", 8'hF0, 0);

      // 2: min with 3-cycle output stall; in_valid in DONE ignored
      start4_t(1'b1);
      q4.push_back('{8'h03, 2});
      feed4(8'h12, 0);
      feed4(8'hF0, 0);
      feed4(8'h03, 0);
      feed4(8'h7F, 0);
      n_acc4 = 0;
      in_valid4 = 1'b1;
      in_data4  = 8'h00;
      hs4("t2", 8'h03, 3);
      in_valid4 = 1'b0;
      chk("t2_no_accept_done", n_acc4, 0);

      // 3: ties and boundaries
      start4_t(1'b0);
      q4.push_back('{8'h55, 0});
      feed4(8'h55, 0);
      feed4(8'h55, 0);
      feed4(8'h10, 0);
      feed4(8'h55, 0);
      hs4("t3tie", 8'h55, 0);
      start4_t(1'b0);
      q4.push_back('{8'hFF, 1});
      feed4(8'h00, 0);
      feed4(8'hFF, 0);
      feed4(8'h80, 0);
      feed4(8'h01, 0);
      hs4("t3max", 8'hFF, 0);
      start4_t(1'b1);
      q4.push_back('{8'h00, 0});
      feed4(8'h00, 0);
      feed4(8'hFF, 0);
      feed4(8'h80, 0);
      feed4(8'h01, 0);
      hs4("t3min", 8'h00, 0);

      // 4: start+in_valid in IDLE, gaps, start/select mid-frame
      n_acc4 = 0;
      start4    = 1'b1;
      select4   = 1'b0;
      in_valid4 = 1'b1;
      in_data4  = 8'hEE;
      tick();
      start4    = 1'b0;
      in_valid4 = 1'b0;
      chk("t4_idle_no_take", n_acc4, 0);
      q4.push_back('{8'h30, 2});
      feed4(8'h10, 2);
      feed4(8'h20, 0);
      select4 = 1'b1;
      start4  = 1'b1;
      feed4(8'h30, 3);
      feed4(8'h05, 1);
      chk("t4_accepts", n_acc4, 4);
      start4 = 1'b1;
      tick();
      chk("t4_done_hold", {31'd0, out_valid4}, 1);
      hs4("t4", 8'h30, 0);
      start4 = 1'b0;
      tick();
      chk("t4_start_ignored", {31'd0, busy4}, 0);

      // 5: reset mid-frame, then clean frame
      start4_t(1'b0);
      feed4(8'hFF, 0);
      feed4(8'hEE, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_busy", {31'd0, busy4}, 0);
      chk("t5_valid", {31'd0, out_valid4}, 0);
      chk("t5_in_ready", {31'd0, in_ready4}, 0);
      start4_t(1'b0);
      q4.push_back('{8'h04, 3});
      feed4(8'h01, 0);
      feed4(8'h02, 0);
      feed4(8'h03, 0);
      feed4(8'h04, 0);
      hs4("t5", 8'h04, 0);

      // 6: FRAME_LEN=1, back-to-back
      start1  = 1'b1;
      select1 = 1'b1;
      tick();
      start1 = 1'b0;
      q1.push_back('{8'hA5, 0});
      in_valid1 = 1'b1;
      in_data1  = 8'hA5;
      tick();
      in_valid1 = 1'b0;
      chk("t6_latency", {31'd0, out_valid1}, 1);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      chk("t6_idle", {31'd0, busy1}, 0);
      start1  = 1'b1;
      select1 = 1'b0;
      tick();
      start1 = 1'b0;
      q1.push_back('{8'h3C, 0});
      in_valid1 = 1'b1;
      in_data1  = 8'h3C;
      tick();
      in_valid1 = 1'b0;
      chk("t6b_latency", {31'd0, out_valid1}, 1);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      chk("t6b_idle", {31'd0, busy1}, 0);
      chk("t6_accepts", n_acc1, 2);

      tick();
      chk("sb4_drained", q4.size(), 0);
      chk("sb1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mms_stream_ctrl.md
Name: mms_stream_ctrl

Overview:
Frame-level controller that sequences a single shared 2-input min/max compare stage over a serial stream of unsigned samples. It accepts FRAME_LEN samples through a valid/ready handshake and keeps a running winner: maximum when select=0, minimum when select=1. It then presents the frame result through a valid/ready output handshake. It sits above the combinational min/max selectors and lets one comparator serve frames of arbitrary length instead of a fixed 4-input tree.

Parameters:
DW, 8, sample and result width in bits (unsigned)
FRAME_LEN, 8, samples per frame; legal range 1..255
CW, $clog2(FRAME_LEN+1), sample counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  begin a frame; sampled only in IDLE
select  input  1  0 = max, 1 = min; latched on accepted start
in_valid  input  1  in_data is valid
in_data  input  DW  sample
in_ready  output  1  controller accepts a sample this cycle
out_valid  output  1  result is valid
out_ready  input  1  consumer accepts result
result  output  DW  frame min/max
busy  output  1  high in any state except IDLE

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: state=IDLE, in_ready=0, out_valid=0, result=0, busy=0, count=0, acc=0, sel_q=0.
- States:
  - IDLE: in_ready=0. On start=1, latch sel_q<=select, clear count, and go to ACCUM.
  - ACCUM: in_ready=1. A sample is accepted when in_valid && in_ready.
    - First accepted sample: acc<=in_data.
    - Each later sample: acc<=((acc<in_data)^sel_q) ? in_data : acc. Ties keep acc.
    - count increments per accepted sample. When the accepted sample is number FRAME_LEN (count==FRAME_LEN-1 at acceptance), go to DONE.
  - DONE: in_ready=0, out_valid=1, result=acc, held stable until out_ready=1. The cycle out_valid&&out_ready are both high completes the handshake; the next state is IDLE with out_valid=0.
- Latency: out_valid rises the cycle after the last sample is accepted. Minimum frame time is FRAME_LEN+2 cycles from start to result handshake with no stalls.
- Comparison is unsigned, DW bits, with no width growth.
- in_valid low in ACCUM stalls; acc and count hold.
- start outside IDLE is ignored, including in DONE in the same cycle as out_ready. The next frame requires start while in IDLE.
- in_valid in IDLE or DONE: no acceptance and no state change. The producer must hold the data.
- start and in_valid both high in IDLE: only start is taken; the sample is accepted the next cycle at the earliest.
- select changes after start have no effect until the next frame.
- FRAME_LEN=1: first accepted sample goes directly to DONE with result=sample.
- Reset in any state aborts the frame immediately; the partial result is discarded and out_valid drops in the following cycle.
- result retains the last frame value after the handshake until the next DONE. It is only meaningful while out_valid=1.

Optional Feature:
MMS_INDEX_EN
- Defined: adds output result_idx [CW-1:0], the 0-based position within the frame of the winning sample.
  - Loaded as 0 on the first sample; updated to count whenever the compare selects in_data.
  - Ties keep the earlier index.
  - Valid with result; reset value 0.
- Not defined: port and index register absent; behaviour otherwise identical.

Test Plan:
1. FRAME_LEN=4, select=0, samples 8'h12, 8'hF0, 8'h03, 8'h7F with no stalls -> out_valid the cycle after the 4th accept, result=8'hF0 (idx=1 with MMS_INDEX_EN).
2. Same samples with select=1 and out_ready held low 3 cycles -> result=8'h03 held stable with out_valid=1 through the stall, then IDLE the cycle after the handshake.
3. Ties: select=0, samples 8'h55, 8'h55, 8'h10, 8'h55 -> result=8'h55, idx=0. Boundaries: samples 8'h00 and 8'hFF -> max=8'hFF, min=8'h00.
4. Handshake edges:
   - Random in_valid gaps -> exactly 4 accepts.
   - start and in_valid pulsed in IDLE -> no sample taken.
   - start asserted in ACCUM/DONE -> ignored.
   - select toggled mid-frame -> no effect.
5. Reset asserted after 2 of 4 samples -> next cycle IDLE, busy=0, out_valid=0. A new frame 8'h01, 8'h02, 8'h03, 8'h04 (max) -> result=8'h04, unaffected by the aborted data.
6. FRAME_LEN=1, select=1, sample 8'hA5 -> DONE the next cycle with result=8'hA5; back-to-back frames with start in the cycle after the handshake -> both correct.
